// File: rtl/hex_scroll_pkg.sv
// Shared types and constants for the scrolling hex display driver.
package hex_scroll_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [4:0] char_t;

    localparam char_t CHAR_BLANK = 5'd16;
    localparam char_t CHAR_DASH  = 5'd17;

    // Active-low gfedcba patterns for the non-hex glyphs
    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        SHIFT = 2'd3
    } state_t;

endpackage

// File: rtl/hex_scroll_driver_seg7_decoder.sv
// Combinational character-code to active-low seven-segment (gfedcba) decoder.
module seg7_decoder
    import hex_scroll_pkg::*;
(
    input  char_t code,
    output seg7_t seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'd0:      seg = 7'h40;
            5'd1:      seg = 7'h79;
            5'd2:      seg = 7'h24;
            5'd3:      seg = 7'h30;
            5'd4:      seg = 7'h19;
            5'd5:      seg = 7'h12;
            5'd6:      seg = 7'h02;
            5'd7:      seg = 7'h78;
            5'd8:      seg = 7'h00;
            5'd9:      seg = 7'h10;
            5'd10:     seg = 7'h08;
            5'd11:     seg = 7'h03;
            5'd12:     seg = 7'h46;
            5'd13:     seg = 7'h21;
            5'd14:     seg = 7'h06;
            5'd15:     seg = 7'h0E;
            CHAR_DASH: seg = SEG_DASH;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scroll_driver.sv
// Scrolls characters from an upstream buffer across NUM_DIGITS seven-segment digits.
// Define HEX_SCROLL_FAST_SIM_EN to force the scroll divider to 4 clocks.
module hex_scroll_driver
    import hex_scroll_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int SCROLL_HZ   = 2,
    parameter int NUM_DIGITS  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    clear,
    input  char_t                   hex_char,
    output logic                    next_char,
    output logic [NUM_DIGITS*7-1:0] hex_out,
    output state_t                  fsm_state
);

`ifdef HEX_SCROLL_FAST_SIM_EN
    localparam int DIV = 4;
`else
    localparam int DIV = CLK_FREQ_HZ / SCROLL_HZ;
`endif
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             sample_en;
    logic             shift_en;
    char_t            sampled;
    char_t            digits [NUM_DIGITS];

    // The prescaler only runs while idle, so a full scroll period is DIV + 3 cycles.
    assign tick = enable && (state == IDLE) && (count == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || !enable || (state != IDLE) || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Buffer handshake: next_char is a single-cycle request raised in REQ; the
    // buffer must present hex_char by the end of the following (WAIT) cycle, where
    // it is captured. There is no back-pressure in either direction.
    always_comb begin
        next_state = state;
        next_char  = 1'b0;
        sample_en  = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE:  if (tick) next_state = REQ;
            REQ: begin
                next_char  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                sample_en  = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                shift_en   = !clear;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (clear) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sampled <= CHAR_BLANK;
        end else if (sample_en) begin
            sampled <= hex_char;
        end
    end

    // Newest character enters at digit 0 (rightmost) and older ones move left.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_DIGITS; k++) digits[k] <= CHAR_BLANK;
        end else if (clear) begin
            for (int k = 0; k < NUM_DIGITS; k++) digits[k] <= CHAR_BLANK;
        end else if (shift_en) begin
            for (int k = NUM_DIGITS - 1; k > 0; k--) digits[k] <= digits[k-1];
            digits[0] <= sampled;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_decoder u_dec (
            .code (digits[g]),
            .seg  (hex_out[7*g +: 7])
        );
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_hex_scroll_driver.sv
// Directed-plus-random bench for hex_scroll_driver against a queue-based display model.
module tb_hex_scroll_driver;
    import hex_scroll_pkg::*;

    localparam int NUM_DIGITS = 6;
    localparam int DIV        = 4;
    localparam int HEX_W      = NUM_DIGITS * 7;
    localparam int WAIT_BOUND = 60;

    // Active-high lit-segment sets (gfedcba) for hex digits 0..F
    localparam logic [6:0] LIT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             clear;
    logic [4:0]       hex_char;
    logic             next_char;
    logic [HEX_W-1:0] hex_out;
    state_t           fsm_state;

    logic [4:0] disp_q[$];
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    hex_scroll_driver #(
        .CLK_FREQ_HZ (8),
        .SCROLL_HZ   (2),
        .NUM_DIGITS  (NUM_DIGITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clear     (clear),
        .hex_char  (hex_char),
        .next_char (next_char),
        .hex_out   (hex_out),
        .fsm_state (fsm_state)
    );

    function automatic logic [6:0] glyph(input int code);
        if (code < 16) return ~LIT[code];
        if (code == 17) return ~7'h40;
        return 7'h7F;
    endfunction

    function automatic logic [HEX_W-1:0] expected_hex();
        logic [HEX_W-1:0] e;
        e = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            e[7*k +: 7] = (k < disp_q.size()) ? glyph(int'(disp_q[k])) : glyph(16);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_req(input int expect_gap, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!next_char && n < WAIT_BOUND);
        check(tag, 64'(n), 64'(expect_gap));
    endtask

    // Called at the falling edge inside the REQ cycle.
    task automatic tick(input logic [4:0] code, input bit drop_en);
        if (drop_en) enable = 1'b0;
        hex_char = code ^ 5'($urandom_range(1, 31));
        @(negedge clk);
        check("pulse_width", 64'(next_char), 64'(0));
        hex_char = code;
        @(negedge clk);
        hex_char = code ^ 5'($urandom_range(1, 31));
        check("pre_shift", 64'(hex_out), 64'(expected_hex()));
        disp_q.push_front(code);
        if (disp_q.size() > NUM_DIGITS) void'(disp_q.pop_back());
        @(negedge clk);
        check("shift", 64'(hex_out), 64'(expected_hex()));
    endtask

    initial begin
        int pulses;
        rst      = 1'b0;
        enable   = 1'b0;
        clear    = 1'b0;
        hex_char = '0;
        repeat (3) @(negedge clk);
        check("reset_hex", 64'(hex_out), 64'({HEX_W{1'b1}}));
        check("reset_next", 64'(next_char), 64'(0));
        check("reset_state", 64'(fsm_state), 64'(IDLE));

        rst    = 1'b1;
        enable = 1'b1;
        wait_req(DIV, "first_req");
        tick(5'd5, 1'b0);
        check("digit0_five", 64'(hex_out[6:0]), 64'(7'b0010010));

        for (int c = 1; c <= 6; c++) begin
            wait_req(DIV, "period");
            tick(5'(c), 1'b0);
        end
        check("digit5_one", 64'(hex_out[41:35]), 64'(glyph(1)));
        check("digit0_six", 64'(hex_out[6:0]), 64'(glyph(6)));

        wait_req(DIV, "period");
        tick(5'd17, 1'b0);
        check("digit0_dash", 64'(hex_out[6:0]), 64'(7'b0111111));
        check("digit5_two", 64'(hex_out[41:35]), 64'(glyph(2)));

        wait_req(DIV, "period");
        tick(5'd25, 1'b0);
        check("digit0_code25", 64'(hex_out[6:0]), 64'(7'h7F));

        repeat (8) begin
            wait_req(DIV, "period");
            tick(5'($urandom_range(0, 31)), 1'b0);
        end

        wait_req(DIV, "period");
        @(negedge clk);
        clear    = 1'b1;
        hex_char = 5'($urandom_range(0, 15));
        @(negedge clk);
        clear = 1'b0;
        disp_q.delete();
        check("clear_hex", 64'(hex_out), 64'({HEX_W{1'b1}}));
        check("clear_state", 64'(fsm_state), 64'(IDLE));
        wait_req(DIV, "req_after_clear");
        check("no_shift_after_clear", 64'(hex_out), 64'({HEX_W{1'b1}}));

        tick(5'($urandom_range(0, 31)), 1'b1);
        pulses = 0;
        repeat (100) begin
            @(negedge clk);
            if (next_char) pulses++;
        end
        check("disabled_pulses", 64'(pulses), 64'(0));
        check("disabled_hex", 64'(hex_out), 64'(expected_hex()));
        enable = 1'b1;
        wait_req(DIV, "req_after_enable");

        rst = 1'b0;
        hex_char = 5'($urandom_range(0, 15));
        @(negedge clk);
        disp_q.delete();
        check("midreq_reset_next", 64'(next_char), 64'(0));
        check("midreq_reset_hex", 64'(hex_out), 64'({HEX_W{1'b1}}));
        check("midreq_reset_state", 64'(fsm_state), 64'(IDLE));
        repeat (2) @(negedge clk);
        check("reset_hold_hex", 64'(hex_out), 64'(expected_hex()));
        rst = 1'b1;
        wait_req(DIV, "req_after_reset");
        tick(5'($urandom_range(0, 31)), 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
